mips_hilo_muldiv: RTL and testbench

//   Iterative multiply/divide unit with the architectural HI/LO registers for the multicycle MIPS core.

---
 rtl/mips_hilo_muldiv.sv | 141 ++++++++++++++
 tb/tb_mips_hilo_muldiv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_hilo_muldiv.sv
// Iterative shift-add multiplier / restoring divider with the HI/LO registers.
// One operand bit per cycle; a final FIXUP cycle applies the signs and writes back.
module mips_hilo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MUL   = 2'd1;
   localparam logic [1:0] S_DIV   = 2'd2;
   localparam logic [1:0] S_FIXUP = 2'd3;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opd;
   logic               neg_q;
   logic               neg_r;
   logic               is_div;

   logic               issue;
   logic               sgn;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;

   assign issue = start & (state == S_IDLE);
   assign stall = busy | (start & ~busy & ~op[2]);
   assign sgn   = ~op[0];
   assign a_neg = sgn & a[WIDTH-1];
   assign b_neg = sgn & b[WIDTH-1];
   assign a_abs = a_neg ? -a : a;
   assign b_abs = b_neg ? -b : b;

   // acc holds {partial product, remaining multiplier bits}
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // acc holds {partial remainder, dividend bits / quotient bits}
   logic [WIDTH:0]     div_t;
   logic               div_ge;
   logic [WIDTH-1:0]   div_d;
   logic [WIDTH-1:0]   rem_n;
   logic [2*WIDTH-1:0] div_next;

   assign div_t    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_ge   = div_t >= {1'b0, opd};
   assign div_d    = div_t[WIDTH-1:0] - opd;
   assign rem_n    = div_ge ? div_d : div_t[WIDTH-1:0];
   assign div_next = {rem_n, acc[WIDTH-2:0], div_ge};

   logic [2*WIDTH-1:0] prod_f;
   logic [WIDTH-1:0]   quo_f;
   logic [WIDTH-1:0]   rem_f;

   assign prod_f = neg_q ? -acc : acc;
   assign quo_f  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_f  = neg_r ? -acc[2*WIDTH-1:WIDTH]
                         : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         opd    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_div <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (1'b1)
            issue: begin
               unique case (1'b1)
                  (op[2:1] == 2'b00): begin
                     state  <= S_MUL;
                     busy   <= 1'b1;
                     cnt    <= '0;
                     acc    <= {{WIDTH{1'b0}}, b_abs};
                     opd    <= a_abs;
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= 1'b0;
                     is_div <= 1'b0;
                  end
                  (op[2:1] == 2'b01): begin
                     state  <= S_DIV;
                     busy   <= 1'b1;
                     cnt    <= '0;
                     acc    <= {{WIDTH{1'b0}}, a_abs};
                     opd    <= b_abs;
                     // divide by zero leaves the all-ones quotient unsigned
                     neg_q  <= (a_neg ^ b_neg) & (b != '0);
                     neg_r  <= a_neg;
                     is_div <= 1'b1;
                  end
                  (op == 3'b100): hi <= a;
                  (op == 3'b101): lo <= a;
                  default: ;
               endcase
            end
            (state == S_MUL), (state == S_DIV): begin
               acc <= (state == S_DIV) ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state <= S_FIXUP;
            end
            (state == S_FIXUP): begin
               hi    <= is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];
               lo    <= is_div ? quo_f : prod_f[WIDTH-1:0];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// Scoreboard bench for mips_hilo_muldiv: directed mul/div/move vectors,
// busy/stall timing, mid-operation start and asynchronous reset.
module tb_mips_hilo_muldiv;

   localparam int W = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         stall;
   logic         done;

   mips_hilo_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .stall (stall),
      .done  (done)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           failures = 0;
   int           dones = 0;
   int           pushes = 0;
   logic [63:0]  expq[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         dones++;
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected actual=1 required=0");
         end else begin
            logic [63:0] e;
            e = expq.pop_front();
            chk("result_hilo", {hi, lo}, e);
         end
      end
   end

   task automatic run_md(input string name, input logic [2:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input bit inject);
      int n;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      expq.push_back({eh, el});
      pushes++;
      #1 chk({name, "_stall_start"}, 64'(stall), 64'(1));
      @(negedge clk);
      start = 1'b0;
      a     = ~x;
      b     = ~y;
      n     = 0;
      while (busy && n < 100) begin
         n++;
         if (n == 16)
            chk({name, "_hold"}, {hi, lo}, {m_hi, m_lo});
         if (inject && n == 5) begin
            start = 1'b1;
            op    = OP_MULTU;
            a     = 32'hFFFF;
            b     = 32'hFFFF;
            #1 chk({name, "_stall_busy"}, 64'(stall), 64'(1));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({name, "_busy_cycles"}, 64'(n), 64'(W + 1));
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      #1;
      chk("reset_state", {hi, lo, 30'd0, busy, done}, 96'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_md("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_md("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5,
             32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run_md("mult_min", OP_MULT, 32'h80000000, 32'h80000000,
             32'h40000000, 32'h00000000, 1'b0);
      run_md("multu_mid", OP_MULTU, 32'h12345678, 32'd9,
             32'h00000000, 32'hA3D70A38, 1'b0);
      run_md("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_md("divu_small", OP_DIVU, 32'd7, 32'd2,
             32'd1, 32'd3, 1'b0);
      run_md("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10,
             32'h0000000F, 32'h0FFFFFFF, 1'b0);
      run_md("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000, 1'b0);
      run_md("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'd0,
             32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
      run_md("multu_inject", OP_MULTU, 32'd6, 32'd7,
             32'd0, 32'd42, 1'b1);

      // MTHI then MTLO back to back
      @(negedge clk);
      start = 1'b1;
      op    = OP_MTHI;
      a     = 32'hDEADBEEF;
      #1 chk("mthi_stall", 64'(stall), 64'(0));
      @(negedge clk);
      chk("mthi_hi", 64'(hi), 64'(32'hDEADBEEF));
      op = OP_MTLO;
      a  = 32'd1;
      #1 chk("mtlo_stall", 64'(stall), 64'(0));
      @(negedge clk);
      chk("mtlo_hilo", {hi, lo}, {32'hDEADBEEF, 32'd1});
      chk("mtlo_busy_done", {busy, done}, 64'(0));

      // unused op code
      op = 3'b110;
      a  = 32'h55555555;
      #1 chk("nop_stall", 64'(stall), 64'(0));
      @(negedge clk);
      start = 1'b0;
      chk("nop_hilo", {hi, lo}, {32'hDEADBEEF, 32'd1});
      chk("nop_busy", 64'(busy), 64'(0));
      m_hi = 32'hDEADBEEF;
      m_lo = 32'd1;

      run_md("div_zero", OP_DIV, 32'h12345678, 32'd0,
             32'h12345678, 32'hFFFFFFFF, 1'b0);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      start = 1'b1;
      op    = OP_DIV;
      a     = 32'd100;
      b     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_div", {hi, lo, 30'd0, busy, done}, 96'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_hi  = '0;
      m_lo  = '0;
      repeat (40) @(negedge clk);
      chk("rst_after", {hi, lo, 31'd0, busy}, 96'd0);

      run_md("divu_after_rst", OP_DIVU, 32'd100, 32'd3,
             32'd1, 32'd33, 1'b0);

      repeat (3) @(negedge clk);
      chk("done_count", 64'(dones), 64'(pushes));
      chk("queue_empty", 64'(expq.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
